uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit path among two requesters (e.g. game-state and car-position producers).
- Round-robin arbitration; the winner's fixed-length payload is serialised into a framed message: header, payload, XOR checksum.
- The framed bytes are pushed into the UART's one-byte TX flag buffer via the wr_uart / tx_full handshake.
- Sits between the game logic and uart_ff_buf.

---
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART TX path between
// two requesters. The winning requester's payload is framed as
// header, payload bytes (MSB first), XOR checksum. Each byte is handed to
// the UART's one-byte flag buffer through the wr_uart / tx_full handshake.
module uart_tx_arbiter #(
  parameter int         PLEN     = 4,
  parameter logic [7:0] HDR_BASE = 8'hA0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic [8*PLEN-1:0] payload0,
  input  logic [8*PLEN-1:0] payload1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic              busy,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WR   = 2'd2
  } state_t;

  // Index of the last payload byte; the byte after it is the checksum.
  localparam logic [4:0] LAST_PAYLOAD = 5'(PLEN);

  state_t            state;
  state_t            state_next;
  logic              rr;
  logic              rr_next;
  logic              winner;
  logic [8*PLEN-1:0] shift;
  logic [8*PLEN-1:0] shift_next;
  logic [7:0]        cur_byte;
  logic [7:0]        cur_next;
  logic [7:0]        checksum;
  logic [7:0]        checksum_next;
  logic [4:0]        index;
  logic [4:0]        index_next;
  logic [1:0]        grant_next;
  logic [1:0]        done_next;

  // Pick the winner: a lone requester wins, a tie goes away from the last owner.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~rr;
      default: winner = 1'b0;
    endcase
  end

  // Next-state and datapath updates for capture, handshake wait and byte write.
  // rr doubles as the current frame owner: it is loaded at capture and held.
  always_comb begin
    state_next    = state;
    rr_next       = rr;
    shift_next    = shift;
    cur_next      = cur_byte;
    checksum_next = checksum;
    index_next    = index;
    grant_next    = grant;
    done_next     = 2'b00;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_next    = winner ? 2'b10 : 2'b01;
          rr_next       = winner;
          shift_next    = winner ? payload1 : payload0;
          cur_next      = HDR_BASE | {7'b0000000, winner};
          checksum_next = 8'h00;
          index_next    = 5'd0;
          state_next    = SEND;
        end
      end
      SEND: begin
        if (!tx_full) begin
          state_next = WR;
        end
      end
      WR: begin
        checksum_next = checksum ^ cur_byte;
        index_next    = index + 5'd1;
        if (index < LAST_PAYLOAD) begin
          cur_next   = shift[8*PLEN-1 -: 8];
          shift_next = shift << 8;
          state_next = SEND;
        end else if (index == LAST_PAYLOAD) begin
          cur_next   = checksum ^ cur_byte;
          state_next = SEND;
        end else begin
          done_next  = rr ? 2'b10 : 2'b01;
          grant_next = 2'b00;
          index_next = 5'd0;
          state_next = IDLE;
        end
      end
      default: begin
        grant_next = 2'b00;
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr       <= 1'b1;
      shift    <= '0;
      cur_byte <= 8'h00;
      checksum <= 8'h00;
      index    <= 5'd0;
      grant    <= 2'b00;
      done     <= 2'b00;
    end else begin
      state    <= state_next;
      rr       <= rr_next;
      shift    <= shift_next;
      cur_byte <= cur_next;
      checksum <= checksum_next;
      index    <= index_next;
      grant    <= grant_next;
      done     <= done_next;
    end
  end

  // Handshake outputs are decoded from registered state only.
  always_comb begin
    busy    = (state != IDLE);
    wr_uart = (state == WR);
    w_data  = (state == WR) ? cur_byte : 8'h00;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter with a
// frame-level reference model (byte queue per frame) compared every cycle.
module tb_uart_tx_arbiter;

  localparam int         PLEN = 4;
  localparam logic [7:0] HDR  = 8'hA0;

  logic            clk;
  logic            reset_n;
  logic [1:0]      req;
  logic [31:0]     payload0;
  logic [31:0]     payload1;
  logic [1:0]      grant;
  logic [1:0]      done;
  logic            busy;
  logic            tx_full;
  logic            wr_uart;
  logic [7:0]      w_data;

  int tests;
  int errors;
  int tx_mode;
  int hold;
  int done_total;
  logic saw_wr;
  logic [7:0] log_q[$];

  // reference model state
  logic [7:0] m_q[$];
  logic       m_busy;
  logic       m_wr;
  logic [1:0] m_grant;
  logic [1:0] m_done;
  logic       m_last;
  logic       m_owner;

  uart_tx_arbiter #(.PLEN(PLEN), .HDR_BASE(HDR)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .payload0 (payload0),
    .payload1 (payload1),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    tests++;
    errors++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Frame-level model: on capture the whole frame is built as a byte queue;
  // each byte then takes one wait cycle (tx_full low) and one write cycle.
  always @(posedge clk or negedge reset_n) begin
    logic       w;
    logic [31:0] p;
    logic [7:0] x;
    logic [7:0] b;
    if (!reset_n) begin
      m_q.delete();
      m_busy  = 1'b0;
      m_wr    = 1'b0;
      m_grant = 2'b00;
      m_done  = 2'b00;
      m_last  = 1'b1;
      m_owner = 1'b0;
    end else begin
      m_done = 2'b00;
      if (!m_busy) begin
        if (req != 2'b00) begin
          if (req == 2'b11) w = (m_last == 1'b0);
          else              w = req[1];
          p = w ? payload1 : payload0;
          m_q.delete();
          x = HDR | {7'b0, w};
          m_q.push_back(x);
          for (int k = 0; k < PLEN; k++) begin
            b = p[8*(PLEN-1-k) +: 8];
            m_q.push_back(b);
            x = x ^ b;
          end
          m_q.push_back(x);
          m_owner = w;
          m_last  = w;
          m_grant = w ? 2'b10 : 2'b01;
          m_busy  = 1'b1;
          m_wr    = 1'b0;
        end
      end else if (m_wr) begin
        void'(m_q.pop_front());
        m_wr = 1'b0;
        if (m_q.size() == 0) begin
          m_done[m_owner] = 1'b1;
          m_grant = 2'b00;
          m_busy  = 1'b0;
        end
      end else if (!tx_full) begin
        m_wr = 1'b1;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    saw_wr = wr_uart;
    if (reset_n) begin
      checkOutput("grant", {30'b0, grant}, {30'b0, m_grant});
      checkOutput("done", {30'b0, done}, {30'b0, m_done});
      checkOutput("busy", {31'b0, busy}, {31'b0, m_busy});
      checkOutput("wr_uart", {31'b0, wr_uart}, {31'b0, m_wr});
      if (m_wr) checkOutput("w_data", {24'b0, w_data}, {24'b0, m_q[0]});
      if (tx_mode == 1) checkOutput("wr_while_full", {31'b0, wr_uart & tx_full}, 32'd0);
      if (wr_uart) log_q.push_back(w_data);
      if (done != 2'b00) done_total++;
    end
  end

  // UART flag: 0 = always empty, 1 = busy 20 cycles after each write, 2 = random.
  always begin
    @(posedge clk);
    #1;
    case (tx_mode)
      1: begin
        if (saw_wr) hold = 20;
        else if (hold > 0) hold--;
        tx_full = (hold > 0);
      end
      2: tx_full = 1'($urandom_range(0, 1));
      default: tx_full = 1'b0;
    endcase
  end

  task automatic applyStimulus(input logic [1:0] r, input logic [31:0] p0, input logic [31:0] p1);
    @(posedge clk);
    #1;
    req      = r;
    payload0 = p0;
    payload1 = p1;
  endtask

  task automatic waitGrant();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (grant != 2'b00) return;
    end
    timeoutFail("wait_grant");
  endtask

  task automatic waitDone(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_total >= target) return;
    end
    timeoutFail("wait_done");
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    timeoutFail("wait_idle");
  endtask

  // One frame: request, drop req once granted (optionally changing payload), wait for done.
  task automatic runFrame(input logic [1:0] r, input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] late_p0, output int start);
    int target;
    start  = log_q.size();
    target = done_total + 1;
    applyStimulus(r, p0, p1);
    waitGrant();
    applyStimulus(2'b00, late_p0, p1);
    waitDone(target, 1000);
    waitIdle();
  endtask

  task automatic checkBytes(input string name, input int start, input logic [47:0] exp);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("%s_byte%0d", name, k), {24'b0, log_q[start+k]},
                  {24'b0, exp[8*(5-k) +: 8]});
    end
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_grant"}, {30'b0, grant}, 32'd0);
    checkOutput({name, "_done"}, {30'b0, done}, 32'd0);
    checkOutput({name, "_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({name, "_wr"}, {31'b0, wr_uart}, 32'd0);
    checkOutput({name, "_wdata"}, {24'b0, w_data}, 32'd0);
  endtask

  initial begin
    int s;
    int target;
    tests      = 0;
    errors     = 0;
    tx_mode    = 0;
    hold       = 0;
    done_total = 0;
    saw_wr     = 1'b0;
    reset_n    = 1'b0;
    req        = 2'b00;
    payload0   = 32'h0;
    payload1   = 32'h0;
    #3;
    checkResetOutputs("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // requester 0 alone
    runFrame(2'b01, 32'h11223344, 32'h0, 32'h11223344, s);
    checkBytes("req0", s, 48'hA0_11_22_33_44_E4);

    // requester 1 alone
    runFrame(2'b10, 32'h0, 32'hDEADBEEF, 32'h0, s);
    checkBytes("req1", s, 48'hA1_DE_AD_BE_EF_83);

    // both requesting continuously: headers alternate starting with 0
    s = log_q.size();
    target = done_total + 4;
    applyStimulus(2'b11, 32'h01020304, 32'h05060708);
    waitDone(target, 400);
    applyStimulus(2'b00, 32'h01020304, 32'h05060708);
    waitIdle();
    checkOutput("rr_hdr0", {24'b0, log_q[s]},    32'hA0);
    checkOutput("rr_hdr1", {24'b0, log_q[s+6]},  32'hA1);
    checkOutput("rr_hdr2", {24'b0, log_q[s+12]}, 32'hA0);
    checkOutput("rr_hdr3", {24'b0, log_q[s+18]}, 32'hA1);

    // slow UART: flag held 20 cycles after every write
    tx_mode = 1;
    runFrame(2'b01, 32'h11223344, 32'h0, 32'h11223344, s);
    checkBytes("slow", s, 48'hA0_11_22_33_44_E4);
    tx_mode = 0;
    repeat (25) @(negedge clk);

    // payload change and req drop after capture are ignored
    runFrame(2'b01, 32'hCAFEF00D, 32'h0, 32'hFFFFFFFF, s);
    checkBytes("late", s, 48'hA0_CA_FE_F0_0D_69);

    // randomized traffic with random flag behaviour
    tx_mode = 2;
    for (int i = 0; i < 800; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom);
    end
    applyStimulus(2'b00, 32'h0, 32'h0);
    tx_mode = 0;
    waitIdle();

    // reset in the middle of the payload
    s = log_q.size();
    applyStimulus(2'b01, 32'h11223344, 32'h0);
    for (int i = 0; i < 100 && log_q.size() < s + 3; i++) @(negedge clk);
    req = 2'b00;
    #2;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    runFrame(2'b10, 32'h0, 32'hDEADBEEF, 32'h0, s);
    checkBytes("after_reset", s, 48'hA1_DE_AD_BE_EF_83);

    // fresh reset: pointer restored, so a tie goes to requester 0
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    runFrame(2'b11, 32'h11223344, 32'hDEADBEEF, 32'h11223344, s);
    checkBytes("tie_after_reset", s, 48'hA0_11_22_33_44_E4);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
